mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one memory port between two requesters: requester 0 is instruction fetch, requester 1 is the load/store stage.
- Arbitrates with round-robin priority and sequences each transaction until the memory completes or a watchdog expires.
- Drives the select line of the 2:1 address/write-data muxes, instantiated as MUX_2 inside this block.
- Returns a per-requester completion pulse.

Parameters:
- DATA_WIDTH, 32, width of write/read data.
- ADDR_WIDTH, 32, width of address.
- TIMEOUT, 16, max cycles in a BUSY state without mem_ready before abort; must be >= 2.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0 / req1  input  1  request; held high with stable we/addr/wdata until matching done.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  ADDR_WIDTH  request address.
- wdata0 / wdata1  input  DATA_WIDTH  write data.
- done0 / done1  output  1  one-cycle completion pulse.
- err0 / err1  output  1  one-cycle pulse, coincident with done, on timeout abort.
- rdata  output  DATA_WIDTH  mem_rdata passthrough; valid to a requester only in its done cycle.
- sel  output  1  mux select: 0 = requester 0, 1 = requester 1; registered.
- mem_req  output  1  memory transaction active.
- mem_we  output  1  muxed we.
- mem_addr  output  ADDR_WIDTH  muxed addr.
- mem_wdata  output  DATA_WIDTH  muxed wdata.
- mem_ready  input  1  memory completes the current transaction this cycle.

Behaviour:
- Reset (async, while rst=1): state=IDLE, sel=0, last=1 (requester 0 wins the first tie), cnt=0, mem_req=0, done0=done1=0, err0=err1=0. Register clears are immediate, not clock-gated.
- States: IDLE, BUSY0, BUSY1.
  - mem_req=1 in BUSY0/BUSY1 only; sel=1 in BUSY1 only.
  - mem_we, mem_addr and mem_wdata are muxed combinationally by sel in all states.
- Arbitration function `pick(r0,r1)`:
  - only r0 -> 0; only r1 -> 1.
  - both -> the requester != last; none -> IDLE.
  - On entering BUSYi: last<=i, cnt<=0.
- IDLE: evaluate pick(req0,req1) each edge and enter BUSYi. Grant latency is 1 cycle, so mem_req rises the cycle after req is first seen.
- BUSYi, no mem_ready, cnt<TIMEOUT-1: cnt<=cnt+1 and hold state.
- BUSYi with mem_ready=1:
  - donei=1 combinationally that cycle; rdata=mem_rdata.
  - The next state is chosen in the same edge with pick(), where the finishing requester's req is masked to 0.
  - This gives a back-to-back handoff to the other requester with no IDLE bubble.
- BUSYi with cnt==TIMEOUT-1 and no mem_ready:
  - donei=1 and erri=1 that cycle.
  - Transition is identical to the completion case.
- Simultaneous mem_ready and timeout: treated as normal completion, erri=0.
- A requester keeping req high past its done cycle issues a new request. It competes normally the following cycle.
- req dropping mid-transaction is a protocol violation. The arbiter ignores it and holds BUSYi until mem_ready or timeout.
- done/err are never asserted in IDLE and never for the non-granted requester.
- Reset mid-transaction: mem_req drops asynchronously; no done/err pulse for the aborted transaction.
- cnt width is `$clog2(TIMEOUT)`; it never wraps, because the timeout transition always precedes overflow.

Test Plan:
- Reset, then req0=1, addr0=0x100, we0=0 → mem_req=1, sel=0, mem_addr=0x100 one cycle later. Memory answers mem_ready=1 with mem_rdata=0xDEADBEEF after 3 cycles → done0 pulses one cycle with rdata=0xDEADBEEF; state IDLE.
- req0 and req1 raised in the same cycle from reset → requester 0 granted first. At its mem_ready, sel switches to 1 on the next edge with no IDLE cycle; done1 follows.
- Both requests held continuously, 1-cycle memory → grants alternate 0,1,0,1. Each done pulse is exactly 1 cycle.
- req1=1, we1=1, addr1=0x2000, wdata1=0xAAAA5555 → mem_we=1, mem_addr=0x2000, mem_wdata=0xAAAA5555, sel=1 throughout BUSY1.
- Grant requester 1, hold mem_ready=0 → done1=err1=1 on the 16th BUSY cycle, then IDLE. Repeat with mem_ready=1 on that same cycle → err1=0.
- rst asserted asynchronously mid-BUSY0 → mem_req=0, sel=0, done0=0 immediately, without waiting for a clock edge. After release, a tie grants requester 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request, completion and memory-side signals of the two-port memory arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  done0;
  logic                  done1;
  logic                  err0;
  logic                  err1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  sel;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  // Arbiter side: owns the memory port and answers both requesters.
  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    output done0, done1, err0, err1, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    input  done0, done1, err0, err1, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module MUX_2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             last_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             expired;
  logic             finish;
  logic             sel_int;

  // Both requesting: the one not served last wins.
  function automatic state_t pick(input logic r0, input logic r1, input logic lst);
    if (r0 && r1)  return lst ? BUSY0 : BUSY1;
    else if (r0)   return BUSY0;
    else if (r1)   return BUSY1;
    else           return IDLE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign expired = (cnt == CNT_LAST);
  assign finish  = (state != IDLE) && (bus.mem_ready || expired);

  // The finishing requester is masked so the other one is handed the port without an idle bubble.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE:    state_nxt = pick(bus.req0, bus.req1, last);
      BUSY0:   if (finish) state_nxt = pick(1'b0, bus.req1, last);
               else        cnt_nxt   = cnt + 1'b1;
      BUSY1:   if (finish) state_nxt = pick(bus.req0, 1'b0, last);
               else        cnt_nxt   = cnt + 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (finish)
      cnt_nxt = '0;
    if ((state == IDLE || finish) && state_nxt != IDLE) begin
      last_nxt = (state_nxt == BUSY1);
      cnt_nxt  = '0;
    end
  end

  always_comb begin
    sel_int     = (state == BUSY1);
    bus.sel     = sel_int;
    bus.mem_req = (state != IDLE);
    bus.done0   = (state == BUSY0) && finish;
    bus.done1   = (state == BUSY1) && finish;
    bus.err0    = (state == BUSY0) && expired && !bus.mem_ready;
    bus.err1    = (state == BUSY1) && expired && !bus.mem_ready;
    bus.rdata   = bus.mem_rdata;
  end

  MUX_2 #(.WIDTH(1)) u_mux_we (
    .a (bus.we0),
    .b (bus.we1),
    .s (sel_int),
    .y (bus.mem_we)
  );

  MUX_2 #(.WIDTH(ADDR_WIDTH)) u_mux_addr (
    .a (bus.addr0),
    .b (bus.addr1),
    .s (sel_int),
    .y (bus.mem_addr)
  );

  MUX_2 #(.WIDTH(DATA_WIDTH)) u_mux_wdata (
    .a (bus.wdata0),
    .b (bus.wdata1),
    .s (sel_int),
    .y (bus.mem_wdata)
  );
endmodule
